// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage -- instruction decode stage of a 5-stage RV32I-subset pipeline.
//
// Holds the 32x32 register file, decodes the instruction in IF/ID into ALU /
// memory control, builds the immediate, and detects the load-use hazard
// against the instruction sitting in ID/EX. All outputs are combinational
// from the current inputs and register-file state.
//
// Configuration macro: ID_WRITE_BYPASS_EN
//   defined   : write-first register file (same-cycle WB data is forwarded)
//   undefined : read-before-write (new value visible the following cycle)
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   instr, pc_plus4_in          from IF/ID register
//   wb_reg_write/wb_rd/wb_data  writeback port from MEM/WB
//   ex_mem_read, ex_rd          load flag / destination of the ID/EX instr
//   pc_plus4, rs1_data, rs2_data, imm, rd, funct3, funct7   data to ID/EX
//   reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op
//                               control to ID/EX (zeroed on stall or reset)
//   stall                       hold PC and IF/ID this cycle
// ---------------------------------------------------------------------------
module id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus4_in,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  output logic [31:0] pc_plus4,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] imm,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic        funct7,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic        branch,
  output logic [1:0]  alu_op,
  output logic        stall
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IALU   = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011
  } opcode_e;

  logic [31:0] r_regs [32];

  logic [6:0]  w_opcode;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic        w_wb_en;
  logic        w_uses_rs1;
  logic        w_uses_rs2;
  logic        w_stall;
  logic        w_reg_write;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_mem_to_reg;
  logic        w_alu_src;
  logic        w_branch;
  logic [1:0]  w_alu_op;

  assign w_opcode = instr[6:0];
  assign w_rs1    = instr[19:15];
  assign w_rs2    = instr[24:20];
  assign w_wb_en  = wb_reg_write && (wb_rd != 5'd0);

  // Register file; a writeback presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_wb_en) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
    rs2_data = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
`ifdef ID_WRITE_BYPASS_EN
    if (w_wb_en && (wb_rd == w_rs1)) rs1_data = wb_data;
    if (w_wb_en && (wb_rd == w_rs2)) rs2_data = wb_data;
`endif
  end

  // Main decode plus which source fields are architecturally read.
  always_comb begin
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src    = 1'b0;
    w_branch     = 1'b0;
    w_alu_op     = 2'b00;
    w_uses_rs1   = 1'b0;
    w_uses_rs2   = 1'b0;
    imm          = '0;
    case (w_opcode)
      OP_R: begin
        w_reg_write = 1'b1;
        w_alu_op    = 2'b10;
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = 1'b1;
      end
      OP_IALU: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_alu_op    = 2'b11;
        w_uses_rs1  = 1'b1;
        imm         = {{20{instr[31]}}, instr[31:20]};
      end
      OP_LOAD: begin
        w_reg_write  = 1'b1;
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
        w_alu_src    = 1'b1;
        w_uses_rs1   = 1'b1;
        imm          = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = 1'b1;
        imm         = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        w_branch   = 1'b1;
        w_alu_op   = 2'b01;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
        imm        = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      end
      default: ;
    endcase
  end

  // Load-use hazard: only source fields the opcode actually reads count.
  assign w_stall = !reset && ex_mem_read && (ex_rd != 5'd0) &&
                   ((w_uses_rs1 && (ex_rd == w_rs1)) ||
                    (w_uses_rs2 && (ex_rd == w_rs2)));

  always_comb begin
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    branch     = 1'b0;
    alu_op     = 2'b00;
    if (!reset && !w_stall) begin
      reg_write  = w_reg_write;
      mem_read   = w_mem_read;
      mem_write  = w_mem_write;
      mem_to_reg = w_mem_to_reg;
      alu_src    = w_alu_src;
      branch     = w_branch;
      alu_op     = w_alu_op;
    end
  end

  assign stall    = w_stall;
  assign pc_plus4 = pc_plus4_in;
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign funct7   = instr[30];

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have: clk  input  1  rising-edge clock.
REQ-002 SHALL have: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have: instr  input  32  instruction from IF/ID register.
REQ-004 SHALL have: pc_plus4_in  input  32  PC+4 from IF/ID register.
REQ-005 SHALL have: wb_reg_write, wb_rd, wb_data  input  1/5/32  writeback port from MEM/WB.
REQ-006 SHALL have: ex_mem_read, ex_rd  input  1/5  load flag and destination of the instruction currently in ID/EX.
REQ-007 SHALL have: pc_plus4, rs1_data, rs2_data, imm  output  32 each  operands to ID/EX.
REQ-008 SHALL have: rd, funct3, funct7  output  5/3/1  instr[11:7], instr[14:12], instr[30].
REQ-009 SHALL have: reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch  output  1 each; alu_op  output  2  control to ID/EX.
REQ-010 SHALL have: stall  output  1  hold PC and IF/ID this cycle.

Function
REQ-011 SHALL contain a 32x32 register file written on rising clk when wb_reg_write=1 and wb_rd!=0.
REQ-012 SHALL ignore writes to x0; reads of x0 SHALL return 0.
REQ-013 SHALL read rs1=instr[19:15], rs2=instr[24:20] combinationally.
REQ-014 SHALL decode opcode 0110011 (R): reg_write=1, alu_op=10, alu_src=0.
REQ-015 SHALL decode 0010011 (I-ALU): reg_write=1, alu_src=1, alu_op=11.
REQ-016 SHALL decode 0000011 (load): reg_write, mem_read, mem_to_reg, alu_src=1, alu_op=00.
REQ-017 SHALL decode 0100011 (store): mem_write=1, alu_src=1, alu_op=00.
REQ-018 SHALL decode 1100011 (branch): branch=1, alu_op=01, alu_src=0.
REQ-019 SHALL drive all control outputs 0 for any other opcode (NOP).
REQ-020 SHALL generate imm: I = sext(instr[31:20]); S = sext({instr[31:25],instr[11:7]}); B = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}); R/other = 0.
REQ-021 SHALL pass pc_plus4_in to pc_plus4 unchanged.
REQ-022 SHALL assert stall when ex_mem_read=1, ex_rd!=0, and (ex_rd==rs1 for R/I/load/store/branch, or ex_rd==rs2 for R/store/branch).
REQ-023 SHALL, while stall=1, force all control outputs to 0 (bubble); data outputs remain decoded values.
REQ-024 SHALL NOT assert stall for rs2 match on I-type or load (rs2 field unused).
REQ-025 SHALL produce all outputs combinationally from current inputs and register-file state; zero added latency.

Reset
REQ-026 SHALL clear all 32 registers to 0 on the rising clk edge with reset=1.
REQ-027 SHALL drop any writeback presented in a reset cycle.
REQ-028 SHALL force stall=0 and all control outputs to 0 while reset=1; data outputs unconstrained.
REQ-029 SHALL, after reset deasserts, read 0 from every register until written.

Configuration
REQ-030 SHALL implement write-first bypass when ID_WRITE_BYPASS_EN is defined: if wb_reg_write=1, wb_rd!=0, wb_rd==rs1/rs2, rs1_data/rs2_data SHALL equal wb_data in that same cycle.
REQ-031 SHALL, without ID_WRITE_BYPASS_EN, return the pre-write register value in the write cycle; the new value SHALL be visible from the next cycle.

Verification
REQ-032 SHALL cover: write x5=0x12345678 via WB, next cycle instr=add x1,x5,x0 (0x000280B3) -> rs1_data=0x12345678, reg_write=1, alu_op=10.
REQ-033 SHALL cover: wb write x0=0xFFFFFFFF, then read x0 -> rs1_data=0.
REQ-034 SHALL cover: ex_mem_read=1, ex_rd=6, instr=add x7,x6,x2 -> stall=1, all controls 0; ex_rd=0 same instr -> stall=0.
REQ-035 SHALL cover: instr=addi x1,x0,-1 (0xFFF00093) -> imm=0xFFFFFFFF, alu_src=1; beq offset -8 (0xFE000CE3) -> imm=0xFFFFFFF8, branch=1.
REQ-036 SHALL cover: same-cycle WB x3=0xAA and read x3 (old 0x55) -> 0xAA with ID_WRITE_BYPASS_EN, 0x55 without.
REQ-037 SHALL cover: write x9=0x1, assert reset one cycle with wb write x9=0x2 -> x9 reads 0 after reset.
